// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and state encoding for the FIFO control stage
package fifo_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    NO_OP    = 3'd1,
    WRITE    = 3'd2,
    WR_ERROR = 3'd3,
    READ     = 3'd4,
    RD_ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/fifo_ptr_calc.sv
// rtl/fifo_ptr_calc.sv - combinational next-state, pointer and occupancy calculation
module fifo_ptr_calc
  import fifo_pkg::*;
(
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] head,
  input  logic [ADDR_WIDTH-1:0] tail,
  input  logic [CNT_WIDTH-1:0]  count,
  output state_t                next_state,
  output logic [ADDR_WIDTH-1:0] next_head,
  output logic [ADDR_WIDTH-1:0] next_tail,
  output logic [CNT_WIDTH-1:0]  next_count,
  output logic                  we
);

  logic is_full;
  logic is_empty;

  // head==tail cannot distinguish empty from full, so status comes from count
  assign is_full  = (count == CNT_WIDTH'(DEPTH));
  assign is_empty = (count == '0);

  // Only a lone request moves anything; both or neither requested is a no-op
  always_comb begin
    next_state = NO_OP;
    next_head  = head;
    next_tail  = tail;
    next_count = count;
    we         = 1'b0;
    case ({wr_en, rd_en})
      2'b10: begin
        if (is_full) begin
          next_state = WR_ERROR;
        end else begin
          next_state = WRITE;
          we         = 1'b1;
          next_tail  = tail + ADDR_WIDTH'(1);
          next_count = count + CNT_WIDTH'(1);
        end
      end
      2'b01: begin
        if (is_empty) begin
          next_state = RD_ERROR;
        end else begin
          next_state = READ;
          next_head  = head + ADDR_WIDTH'(1);
          next_count = count - CNT_WIDTH'(1);
        end
      end
      default: begin
        next_state = NO_OP;
      end
    endcase
  end

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - control stage driving the 8x32 register file of the FIFO
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rf_rData,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wAddr,
  output logic [ADDR_WIDTH-1:0] rAddr,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output logic [ADDR_WIDTH:0]   data_count
);

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH-1:0] next_head;
  logic [ADDR_WIDTH-1:0] next_tail;
  logic [ADDR_WIDTH:0]   next_count;
  logic                  calc_we;

  // Next-state logic lives in the combinational calculator
  fifo_ptr_calc u_ptr_calc (
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .head       (head),
    .tail       (tail),
    .count      (count),
    .next_state (next_state),
    .next_head  (next_head),
    .next_tail  (next_tail),
    .next_count (next_count),
    .we         (calc_we)
  );

  // State, pointer and occupancy registers; reset discards contents
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state <= INIT;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= next_state;
      head  <= next_head;
      tail  <= next_tail;
      count <= next_count;
    end
  end

  // Capture the head entry on a successful read; otherwise hold the last word
  always_ff @(posedge clk) begin
    if (reset_n) begin
      d_out <= '0;
    end else if (next_state == READ) begin
      d_out <= rf_rData;
    end
  end

  // Moore flag decode from the registered state; INIT and NO_OP raise nothing
  always_comb begin
    wr_ack = 1'b0;
    wr_err = 1'b0;
    rd_ack = 1'b0;
    rd_err = 1'b0;
    case (state)
      WRITE:    wr_ack = 1'b1;
      WR_ERROR: wr_err = 1'b1;
      READ:     rd_ack = 1'b1;
      RD_ERROR: rd_err = 1'b1;
      default:  ;
    endcase
  end

  assign we         = calc_we;
  assign wAddr      = tail;
  assign rAddr      = head;
  assign data_count = count;
  assign full       = (count == (ADDR_WIDTH + 1)'(1 << ADDR_WIDTH));
  assign empty      = (count == '0);

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - self-checking bench for fifo_ctrl with a register-file model
module tb_fifo_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rf_rData;
  logic        we;
  logic [2:0]  wAddr;
  logic [2:0]  rAddr;
  logic [31:0] d_out;
  logic        full;
  logic        empty;
  logic        wr_ack;
  logic        wr_err;
  logic        rd_ack;
  logic        rd_err;
  logic [3:0]  data_count;

  logic [31:0] wr_data = '0;
  logic [31:0] mem [8];

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state: queue contents plus pointer positions
  logic [31:0] m_q[$];
  int          m_head = 0;
  int          m_tail = 0;
  logic [31:0] m_dout = '0;
  logic [3:0]  m_flags = '0;
  logic        last_we;

  typedef struct {
    logic        rst;
    logic        wr;
    logic        rd;
    logic [31:0] data;
    logic        e_we;
    logic [3:0]  e_cnt;
    logic [3:0]  e_flags;
    logic [31:0] e_dout;
    logic [2:0]  e_waddr;
    logic [2:0]  e_raddr;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  fifo_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .rf_rData   (rf_rData),
    .we         (we),
    .wAddr      (wAddr),
    .rAddr      (rAddr),
    .d_out      (d_out),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .data_count (data_count)
  );

  // Register file stand-in: synchronous write, combinational read
  always @(posedge clk) if (we) mem[wAddr] <= wr_data;
  assign rf_rData = mem[rAddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One clock: drive at negedge, check we, advance model at posedge, check outputs after
  task automatic cycle(input logic rst, input logic wr, input logic rd, input logic [31:0] d);
    logic [3:0] e_cnt;
    @(negedge clk);
    reset_n = rst; wr_en = wr; rd_en = rd; wr_data = d;
    #1;
    last_we = we;
    chk("we", {31'd0, we}, {31'd0, (wr && !rd && m_q.size() < 8)});
    @(posedge clk);
    m_flags = 4'b0000;
    if (rst) begin
      m_q.delete(); m_head = 0; m_tail = 0; m_dout = '0;
    end else if (wr && !rd) begin
      if (m_q.size() == 8) m_flags = 4'b0100;
      else begin m_q.push_back(d); m_tail = (m_tail + 1) % 8; m_flags = 4'b1000; end
    end else if (rd && !wr) begin
      if (m_q.size() == 0) m_flags = 4'b0001;
      else begin m_dout = m_q.pop_front(); m_head = (m_head + 1) % 8; m_flags = 4'b0010; end
    end
    #1;
    e_cnt = 4'(m_q.size());
    chk("data_count", {28'd0, data_count}, {28'd0, e_cnt});
    chk("flags", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, {28'd0, m_flags});
    chk("d_out", d_out, m_dout);
    chk("wAddr", {29'd0, wAddr}, 32'(m_tail));
    chk("rAddr", {29'd0, rAddr}, 32'(m_head));
    chk("full", {31'd0, full}, {31'd0, (e_cnt == 4'd8)});
    chk("empty", {31'd0, empty}, {31'd0, (e_cnt == 4'd0)});
  endtask

  task automatic addv(input logic rst, input logic wr, input logic rd, input logic [31:0] data,
                      input logic e_we, input int e_cnt, input logic [3:0] e_flags,
                      input logic [31:0] e_dout, input int e_waddr, input int e_raddr);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.data = data; v.e_we = e_we;
    v.e_cnt = 4'(e_cnt); v.e_flags = e_flags; v.e_dout = e_dout;
    v.e_waddr = 3'(e_waddr); v.e_raddr = 3'(e_raddr);
    vecs.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;

    // Reset, in-order write/read, underflow
    addv(1, 0, 0, 0,      0, 0, 4'b0000, 32'h0,  0, 0);
    addv(0, 1, 0, 32'h11, 1, 1, 4'b1000, 32'h0,  1, 0);
    addv(0, 1, 0, 32'h22, 1, 2, 4'b1000, 32'h0,  2, 0);
    addv(0, 1, 0, 32'h33, 1, 3, 4'b1000, 32'h0,  3, 0);
    addv(0, 0, 1, 0,      0, 2, 4'b0010, 32'h11, 3, 1);
    addv(0, 0, 1, 0,      0, 1, 4'b0010, 32'h22, 3, 2);
    addv(0, 0, 1, 0,      0, 0, 4'b0010, 32'h33, 3, 3);
    addv(0, 0, 1, 0,      0, 0, 4'b0001, 32'h33, 3, 3);
    addv(0, 0, 0, 0,      0, 0, 4'b0000, 32'h33, 3, 3);
    // Overflow from a clean reset
    addv(1, 0, 0, 0,      0, 0, 4'b0000, 32'h0,  0, 0);
    for (int i = 0; i < 8; i++)
      addv(0, 1, 0, 32'hA0 + i, 1, i + 1, 4'b1000, 32'h0, (i + 1) % 8, 0);
    addv(0, 1, 0, 32'hFF, 0, 8, 4'b0100, 32'h0,  0, 0);
    addv(0, 1, 1, 32'hEE, 0, 8, 4'b0000, 32'h0,  0, 0);
    addv(0, 0, 1, 0,      0, 7, 4'b0010, 32'hA0, 0, 1);
    // Simultaneous request at count 3, then mid-operation reset at count 5
    addv(1, 0, 0, 0,      0, 0, 4'b0000, 32'h0,  0, 0);
    addv(0, 1, 0, 32'hC0, 1, 1, 4'b1000, 32'h0,  1, 0);
    addv(0, 1, 0, 32'hC1, 1, 2, 4'b1000, 32'h0,  2, 0);
    addv(0, 1, 0, 32'hC2, 1, 3, 4'b1000, 32'h0,  3, 0);
    addv(0, 1, 1, 32'hC9, 0, 3, 4'b0000, 32'h0,  3, 0);
    addv(0, 1, 0, 32'hC3, 1, 4, 4'b1000, 32'h0,  4, 0);
    addv(0, 1, 0, 32'hC4, 1, 5, 4'b1000, 32'h0,  5, 0);
    addv(1, 0, 0, 0,      0, 0, 4'b0000, 32'h0,  0, 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].data);
      chk("tbl_we", {31'd0, last_we}, {31'd0, vecs[i].e_we});
      chk("tbl_count", {28'd0, data_count}, {28'd0, vecs[i].e_cnt});
      chk("tbl_flags", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, {28'd0, vecs[i].e_flags});
      chk("tbl_d_out", d_out, vecs[i].e_dout);
      chk("tbl_wAddr", {29'd0, wAddr}, {29'd0, vecs[i].e_waddr});
      chk("tbl_rAddr", {29'd0, rAddr}, {29'd0, vecs[i].e_raddr});
    end

    // Wrap-around: 6 writes, 6 reads, 4 writes crossing 7->0, 4 reads
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 32'h60 + i);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 32'hB0 + i);
    chk("wrap_wAddr", {29'd0, wAddr}, 32'd2);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 0);
      chk("wrap_d_out", d_out, 32'hB0 + i);
    end
    chk("wrap_empty", {31'd0, empty}, 32'd1);

    // Randomized traffic against the model, biased to reach both full and empty
    for (int i = 0; i < 600; i++) begin
      logic r, w, d;
      int   bias;
      bias = (i / 100) % 2;
      r = ($urandom_range(0, 79) == 0);
      w = ($urandom_range(0, 9) < (bias ? 7 : 3));
      d = ($urandom_range(0, 9) < (bias ? 3 : 7));
      cycle(r, w, d, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
